// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake and iterative shift-add multiplier
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             Overflow_o,
    output logic             Illegal_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;

    assign in_ready_o = (state == S_IDLE);
    assign acc_next   = mplier[0] ? (acc + mcand) : acc;
    assign sum        = data1_i + data2_i;
    assign diff       = data1_i - data2_i;

    // Overflow uses the sign-bit rule: operand signs vs. result sign
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ALUCtrl_i)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                          (sum[WIDTH-1] != data1_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) &&
                          (diff[WIDTH-1] != data1_i[WIDTH-1]);
            end
            OP_AND:  alu_res = data1_i & data2_i;
            OP_OR:   alu_res = data1_i | data2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            OP_XOR:  alu_res = data1_i ^ data2_i;
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            out_valid_o <= 1'b0;
            data_o      <= '0;
            Zero_o      <= 1'b0;
            Overflow_o  <= 1'b0;
            Illegal_o   <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        if (ALUCtrl_i == OP_MUL) begin
                            mcand  <= data1_i;
                            mplier <= data2_i;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= S_MUL;
                        end else begin
                            data_o      <= alu_res;
                            Zero_o      <= (alu_res == '0);
                            Overflow_o  <= alu_ovf;
                            Illegal_o   <= alu_ill;
                            out_valid_o <= 1'b1;
                            state       <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        data_o      <= acc_next;
                        Zero_o      <= (acc_next == '0);
                        Overflow_o  <= 1'b0;
                        Illegal_o   <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized bench for alu_seq against a behavioural model
module tb_alu_seq;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        logic         ill;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         in_ready, out_valid, zero, ovf, ill;
    logic [W-1:0] data;

    logic         in_valid8 = 1'b0;
    logic         out_ready8 = 1'b0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic [2:0]   op8 = '0;
    logic         in_ready8, out_valid8, zero8, ovf8, ill8;
    logic [7:0]   data8;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data1_i(a), .data2_i(b), .ALUCtrl_i(op),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .data_o(data), .Zero_o(zero), .Overflow_o(ovf), .Illegal_o(ill)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .data1_i(a8), .data2_i(b8), .ALUCtrl_i(op8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .data_o(data8), .Zero_o(zero8), .Overflow_o(ovf8), .Illegal_o(ill8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [2:0] o);
        res_t r;
        longint sx, sy, s, smax, smin;
        longint unsigned p;
        sx   = $signed(x);
        sy   = $signed(y);
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        r.res = '0;
        r.ovf = 1'b0;
        r.ill = 1'b0;
        case (o)
            3'd0: begin s = sx + sy; r.res = W'(s); r.ovf = (s > smax) || (s < smin); end
            3'd1: begin s = sx - sy; r.res = W'(s); r.ovf = (s > smax) || (s < smin); end
            3'd2: r.res = x & y;
            3'd3: r.res = x | y;
            3'd4: r.res = (sx < sy) ? W'(1) : W'(0);
            3'd5: begin p = {32'd0, x} * {32'd0, y}; r.res = W'(p); end
            3'd6: r.res = x ^ y;
            default: r.ill = 1'b1;
        endcase
        r.zero = (r.res == '0);
        return r;
    endfunction

    // Model: an op completes after its latency, then is held until consumed
    int   m_cnt = 0;
    bit   m_valid = 0;
    res_t m_out;
    res_t m_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   = 0;
            m_valid = 0;
            m_out   = '{default: 0};
        end else if (m_valid) begin
            if (out_ready) m_valid = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1;
                m_out   = m_pend;
            end
        end else if (in_valid) begin
            m_pend = model_calc(a, b, op);
            if (op == 3'b101) m_cnt = W;
            else begin
                m_valid = 1;
                m_out   = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (!m_valid && m_cnt == 0));
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("data", data, m_out.res);
                chk("zero", zero, m_out.zero);
                chk("overflow", ovf, m_out.ovf);
                chk("illegal", ill, m_out.ill);
            end
        end
    end

    task automatic garbage();
        in_valid = 1'($urandom_range(0, 1));
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom);
    endtask

    // Returns the number of negedges from issue until out_valid is seen
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o,
                        output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("send_timeout", 0, 1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        op        = o;
        out_ready = 1'b0;
        lat       = 0;
        do begin
            @(negedge clk);
            lat++;
            garbage();
        end while (!out_valid && lat < 200);
        if (lat >= 200) chk("result_timeout", 0, 1);
    endtask

    task automatic drain(input int hold);
        repeat (hold) begin
            @(negedge clk);
            garbage();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return W'(1);
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o,
                        input logic [7:0] exp_d, input int exp_edges, input logic exp_ovf);
        int lat = 0;
        in_valid8 = 1'b1;
        a8  = x;
        b8  = y;
        op8 = o;
        do begin
            @(negedge clk);
            lat++;
            in_valid8 = 1'b0;
        end while (!out_valid8 && lat < 100);
        chk("w8_data", data8, exp_d);
        chk("w8_edges", 64'(lat - 1), 64'(exp_edges));
        chk("w8_ovf", ovf8, exp_ovf);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        chk("w8_idle", in_ready8, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W-1:0] held;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        chk("rst_data", data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ill", ill, 0);
        chk("rst_ready", in_ready, 1);

        send(32'd5, 32'd7, 3'b000, lat);
        chk("add_data", data, 32'd12);
        chk("add_zero", zero, 0);
        chk("add_lat", 64'(lat - 1), 0);
        chk("add_busy", in_ready, 0);
        drain(0);
        chk("add_ready_back", in_ready, 1);

        send(32'd3, 32'd3, 3'b001, lat);
        chk("sub_data", data, 0);
        chk("sub_zero", zero, 1);
        drain(0);
        send(32'h7FFF_FFFF, 32'd1, 3'b000, lat);
        chk("addovf_data", data, 32'h8000_0000);
        chk("addovf_ovf", ovf, 1);
        drain(1);
        send(32'hFFFF_FFFF, 32'd1, 3'b100, lat);
        chk("slt_data", data, 32'd1);
        drain(0);

        send(32'h0001_2345, 32'h10, 3'b101, lat);
        chk("mul_data", data, 32'h0012_3450);
        chk("mul_edges", 64'(lat - 1), 32);
        drain(0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, lat);
        chk("mul_neg_data", data, 32'd1);
        drain(0);

        send(32'h00F0, 32'h000F, 3'b011, lat);
        held = data;
        drain(5);
        chk("bp_held", held, 32'h00FF);
        chk("bp_released", out_valid, 0);
        chk("bp_ready", in_ready, 1);

        send(32'd9, 32'd9, 3'b111, lat);
        chk("ill_data", data, 0);
        chk("ill_zero", zero, 1);
        chk("ill_flag", ill, 1);
        drain(0);
        send(32'd4, 32'd2, 3'b110, lat);
        chk("post_ill_flag", ill, 0);
        drain(0);

        // Reset lands just before the 10th multiply iteration
        in_valid  = 1'b1;
        a         = 32'h1234;
        b         = 32'h5678;
        op        = 3'b101;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midmul_valid", out_valid, 0);
        chk("midmul_data", data, 0);
        chk("midmul_ready", in_ready, 1);
        send(32'd1, 32'd1, 3'b000, lat);
        chk("after_rst_data", data, 32'd2);
        chk("after_rst_lat", 64'(lat - 1), 0);
        drain(0);

        for (int i = 0; i < 200; i++) begin
            send(pick(), pick(), 3'($urandom), lat);
            drain($urandom_range(0, 3));
        end

        chk_en = 0;
        @(negedge clk);
        run8(8'h0F, 8'h11, 3'b101, 8'hFF, 8, 1'b0);
        run8(8'hFF, 8'hFF, 3'b101, 8'h01, 8, 1'b0);
        run8(8'h7F, 8'h01, 3'b000, 8'h80, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Accepts one operation at a time over a valid/ready input handshake.
- Single-cycle ops return a result after 1 cycle; MUL uses an iterative radix-2 shift-add engine and returns after WIDTH cycles.
- Result, Zero and Overflow flags are held in an output register until the consumer accepts them. Sits between operand fetch and writeback in the multi-cycle core.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2 to 64.
- CNT_W, $clog2(WIDTH), MUL iteration counter width; derived, must not be overridden.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- in_valid_i  input  1  operands and opcode valid.
- in_ready_o  output  1  block can accept an operation.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B.
- ALUCtrl_i  input  3  opcode.
- out_valid_o  output  1  result register holds an unconsumed result.
- out_ready_i  input  1  consumer accepts the result.
- data_o  output  WIDTH  result.
- Zero_o  output  1  data_o == 0.
- Overflow_o  output  1  signed overflow on ADD/SUB; 0 for every other op.
- Illegal_o  output  1  the accepted opcode was reserved.

Behaviour:
- One clock (clk_i); reset is synchronous and active-high (rst_i). The polarity and synchronicity are fixed.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 SLT: signed A<B gives 1, else 0, zero-extended.
  - 101 MUL: low WIDTH bits of A*B.
  - 110 XOR.
  - 111 reserved.
- All arithmetic is modulo 2^WIDTH. Carry out is discarded.
- Reset: state=IDLE; out_valid_o=0, data_o=0, Zero_o=0, Overflow_o=0, Illegal_o=0; MUL accumulator and counter are cleared. Reset wins over every other event, including mid-MUL and while DONE is waiting for the consumer. Any in-flight result is lost.
- in_ready_o = (state==IDLE), combinational from the state only. An input accept is in_valid_i & in_ready_o at a rising edge.
- IDLE, on accept of a non-MUL op: compute combinationally and load the result register and flags; go to DONE. out_valid_o is high the cycle after the accept (latency 1).
- IDLE, on accept of MUL: latch multiplicand=A, multiplier=B, acc=0, cnt=0; go to MUL.
- MUL, each cycle:
  - If multiplier[0]==1, acc += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, cnt++.
  - When cnt==WIDTH-1, the updated acc is written to data_o and the state goes to DONE.
  - out_valid_o rises exactly WIDTH cycles after the accepting edge.
  - in_valid_i and the operand inputs are ignored while in MUL.
- DONE: out_valid_o=1; data_o and all flags are held stable. On out_ready_i==1, go to IDLE and clear out_valid_o at the same edge. No new accept is possible in that same cycle (throughput is at most one op per 2 cycles for single-cycle ops).
- Zero_o = (final data_o == 0), registered with data_o.
- Overflow_o:
  - ADD: A and B have the same sign and the result sign differs from it.
  - SUB: A and B have different signs and the result sign differs from A.
  - All other ops: 0.
- Reserved opcode 111: accepted like a single-cycle op; data_o=0, Zero_o=1, Overflow_o=0, Illegal_o=1. Illegal_o=0 for all legal ops.
- out_ready_i is ignored when out_valid_o==0.
- No combinational path from any input to out_valid_o or data_o.

Test Plan:
- Reset, then ADD A=5, B=7 with out_ready_i=1 → in_ready_o=0 for one cycle; next cycle out_valid_o=1, data_o=12, Zero_o=0, Overflow_o=0.
- SUB A=3, B=3 → data_o=0, Zero_o=1. ADD A=0x7FFFFFFF, B=1 → data_o=0x80000000, Overflow_o=1. SLT A=0xFFFFFFFF, B=1 → data_o=1.
- MUL A=0x12345, B=0x10 with WIDTH=32 → out_valid_o rises exactly 32 cycles after accept with data_o=0x123450. MUL A=0xFFFFFFFF, B=0xFFFFFFFF → data_o=1. Repeat both with WIDTH=8: A=0x0F, B=0x11 → data_o=0xFF after 8 cycles.
- Backpressure: hold out_ready_i=0 for 5 cycles after a result appears → data_o and flags stay stable, in_ready_o stays 0, and changing inputs have no effect; raise out_ready_i → next cycle out_valid_o=0, in_ready_o=1.
- Assert rst_i at MUL iteration 10 → next cycle state is IDLE, out_valid_o=0, data_o=0. A following ADD 1+1 returns 2 with normal latency.
- Opcode 111 with A=9, B=9 → data_o=0, Zero_o=1, Illegal_o=1. The next legal op returns Illegal_o=0.
